// File: rtl/aes128_decryptor.sv
// Iterative AES-128 decryption core: one inverse round per clock, with each earlier
// round key derived on the fly from the round-10 key by the inverse key schedule.
module aes128_decryptor #(
  parameter int NR = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [0:3][0:3][7:0]  in_ct,
  input  logic [0:3][0:3][7:0]  in_key10,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [0:3][0:3][7:0]  out_pt
);
  typedef logic [0:3][0:3][7:0] block_t;
  typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

  state_t     state;
  block_t     s;
  block_t     k;
  block_t     kp;
  block_t     s_next;
  logic [3:0] r;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] p;
    acc = 8'h00;
    p   = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ p;
      p = xtime(p);
    end
    return acc;
  endfunction

  // a^254 is the multiplicative inverse in GF(2^8), and maps 0 to 0 as the S-box needs.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] p;
    logic [7:0] acc;
    p   = a;
    acc = 8'h01;
    for (int i = 0; i < 7; i++) begin
      p   = gf_mul(p, p);
      acc = gf_mul(acc, p);
    end
    return acc;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] x;
    x = gf_inv(a);
    return x ^ {x[3:0], x[7:4]} ^ {x[4:0], x[7:5]} ^ {x[5:0], x[7:6]} ^ {x[6:0], x[7]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] a);
    logic [7:0] y;
    y = {a[1:0], a[7:2]} ^ {a[4:0], a[7:5]} ^ {a[6:0], a[7]} ^ 8'h05;
    return gf_inv(y);
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] i);
    logic [7:0] v;
    case (i)
      4'd1:    v = 8'h01;
      4'd2:    v = 8'h02;
      4'd3:    v = 8'h04;
      4'd4:    v = 8'h08;
      4'd5:    v = 8'h10;
      4'd6:    v = 8'h20;
      4'd7:    v = 8'h40;
      4'd8:    v = 8'h80;
      4'd9:    v = 8'h1b;
      4'd10:   v = 8'h36;
      default: v = 8'h00;
    endcase
    return v;
  endfunction

  function automatic block_t inv_mix(input block_t a);
    block_t o;
    for (int c = 0; c < 4; c++) begin
      for (int i = 0; i < 4; i++) begin
        o[i][c] = gf_mul(8'h0e, a[i][c])          ^ gf_mul(8'h0b, a[2'(i + 1)][c]) ^
                  gf_mul(8'h0d, a[2'(i + 2)][c]) ^ gf_mul(8'h09, a[2'(i + 3)][c]);
      end
    end
    return o;
  endfunction

  // Inverse key schedule: undo the column chain first, then recover column 0.
  always_comb begin
    kp = '0;
    for (int i = 0; i < 4; i++) begin
      kp[i][3] = k[i][3] ^ k[i][2];
      kp[i][2] = k[i][2] ^ k[i][1];
      kp[i][1] = k[i][1] ^ k[i][0];
    end
    kp[0][0] = k[0][0] ^ sbox(kp[1][3]) ^ rcon(r + 4'd1);
    kp[1][0] = k[1][0] ^ sbox(kp[2][3]);
    kp[2][0] = k[2][0] ^ sbox(kp[3][3]);
    kp[3][0] = k[3][0] ^ sbox(kp[0][3]);
  end

  always_comb begin
    s_next = '0;
    for (int i = 0; i < 4; i++) begin
      for (int c = 0; c < 4; c++) begin
        s_next[i][c] = inv_sbox(s[i][2'(c - i)]) ^ kp[i][c];
      end
    end
    if (r != 4'd0) s_next = inv_mix(s_next);
  end

  assign in_ready = (state == IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      s         <= '0;
      k         <= '0;
      r         <= 4'd9;
      out_valid <= 1'b0;
      out_pt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            s     <= in_ct ^ in_key10;
            k     <= in_key10;
            r     <= 4'(NR - 1);
            state <= ROUND;
          end
        end
        ROUND: begin
          s <= s_next;
          k <= kp;
          r <= r - 4'd1;
          if (r == 4'd0) begin
            out_pt    <= s_next;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_aes128_decryptor.sv
// Bench for aes128_decryptor: FIPS-197 vectors plus random blocks produced by a
// forward AES-128 encryption model, with handshake, backpressure and reset scenarios.
module tb_aes128_decryptor;
  typedef logic [0:3][0:3][7:0] blk_t;

  logic clk = 1'b0;
  logic rst;
  logic in_valid;
  logic in_ready;
  blk_t in_ct;
  blk_t in_key10;
  logic out_valid;
  logic out_ready;
  blk_t out_pt;

  int n_checks = 0;
  int n_pass   = 0;

  localparam logic [127:0] B_CT  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_K10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] B_PT  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] C_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C_K10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;
  localparam logic [127:0] C_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C_K0  = 128'h000102030405060708090a0b0c0d0e0f;

  always #5 clk = ~clk;

  aes128_decryptor #(.NR(10)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_ct(in_ct), .in_key10(in_key10), .out_valid(out_valid),
    .out_ready(out_ready), .out_pt(out_pt)
  );

  function automatic blk_t to_blk(input logic [127:0] v);
    blk_t b;
    for (int n = 0; n < 16; n++) b[n % 4][n / 4] = v[127 - 8*n -: 8];
    return b;
  endfunction

  function automatic logic [127:0] from_blk(input blk_t b);
    logic [127:0] v;
    for (int n = 0; n < 16; n++) v[127 - 8*n -: 8] = b[n % 4][n / 4];
    return v;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Forward AES reference: encrypt a random block, then expect the DUT to undo it.
  logic [7:0] sb [256];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] aa;
    logic [7:0] bb;
    acc = 8'h00; aa = a; bb = b;
    while (bb != 8'h00) begin
      if (bb[0]) acc = acc ^ aa;
      aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
      bb = bb >> 1;
    end
    return acc;
  endfunction

  task automatic build_sbox();
    logic [7:0] c63;
    c63 = 8'h63;
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv;
      logic [7:0] y;
      inv = 8'h00;
      for (int c = 1; c < 256; c++) if (gmul(8'(x), 8'(c)) == 8'h01) inv = 8'(c);
      for (int i = 0; i < 8; i++)
        y[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c63[i];
      sb[x] = y;
    end
  endtask

  task automatic aes_enc(input logic [127:0] key, input logic [127:0] pt,
                         output logic [127:0] ct, output logic [127:0] key10);
    logic [31:0] w [44];
    logic [7:0]  st [16];
    logic [7:0]  tmp [16];
    logic [7:0]  rc;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      logic [31:0] t;
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int n = 0; n < 16; n++) st[n] = pt[127 - 8*n -: 8] ^ w[n/4][31 - 8*(n%4) -: 8];
    for (int rnd = 1; rnd <= 10; rnd++) begin
      for (int n = 0; n < 16; n++) st[n] = sb[st[n]];
      for (int row = 0; row < 4; row++)
        for (int c = 0; c < 4; c++) tmp[row + 4*c] = st[row + 4*((c + row) % 4)];
      for (int n = 0; n < 16; n++) st[n] = tmp[n];
      if (rnd < 10) begin
        for (int c = 0; c < 4; c++)
          for (int j = 0; j < 4; j++)
            tmp[4*c + j] = gmul(st[4*c + j], 8'h02) ^ gmul(st[4*c + (j+1)%4], 8'h03) ^
                           st[4*c + (j+2)%4] ^ st[4*c + (j+3)%4];
        for (int n = 0; n < 16; n++) st[n] = tmp[n];
      end
      for (int n = 0; n < 16; n++) st[n] = st[n] ^ w[4*rnd + n/4][31 - 8*(n%4) -: 8];
    end
    for (int n = 0; n < 16; n++) ct[127 - 8*n -: 8] = st[n];
    key10 = {w[40], w[41], w[42], w[43]};
  endtask

  // Presents a block, waits for acceptance, then counts cycles until out_valid (-1 on timeout).
  task automatic send_block(input logic [127:0] ct, input logic [127:0] key,
                            input bit scramble, output int lat);
    int guard;
    in_ct = to_blk(ct); in_key10 = to_blk(key); in_valid = 1'b1;
    guard = 0;
    while (!in_ready && guard < 100) begin @(posedge clk); #1; guard++; end
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 50) begin
      if (scramble) begin in_ct = to_blk(rnd128()); in_key10 = to_blk(rnd128()); end
      @(posedge clk); #1; lat++;
    end
    if (!out_valid) lat = -1;
  endtask

  task automatic test_reset();
    rst = 1'b1; out_ready = 1'b0;
    in_valid = 1'b1; in_ct = to_blk(B_CT); in_key10 = to_blk(B_K10);
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready); else n_pass++;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid); else n_pass++;
    n_checks++; if (from_blk(out_pt) !== 128'h0) $display("FAIL reset_out_pt: got %h want 0", from_blk(out_pt)); else n_pass++;
    n_checks++; if (dut.r !== 4'd9) $display("FAIL reset_round: got %0d want 9", dut.r); else n_pass++;
    n_checks++; if (from_blk(dut.s) !== 128'h0 || from_blk(dut.k) !== 128'h0)
      $display("FAIL reset_regs: got s=%h k=%h want 0", from_blk(dut.s), from_blk(dut.k)); else n_pass++;
    rst = 1'b0; in_valid = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL reset_ignores_in_valid: in_ready %b want 1", in_ready); else n_pass++;
  endtask

  task automatic test_fips_b();
    int lat;
    out_ready = 1'b1;
    send_block(B_CT, B_K10, 1'b0, lat);
    n_checks++; if (lat !== 10) $display("FAIL b_latency: got %0d want 10", lat); else n_pass++;
    n_checks++; if (from_blk(out_pt) !== B_PT) $display("FAIL b_plaintext: got %h want %h", from_blk(out_pt), B_PT); else n_pass++;
    n_checks++; if (in_ready !== 1'b0) $display("FAIL b_busy_in_ready: got %b want 0", in_ready); else n_pass++;
    @(posedge clk); #1;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL b_valid_one_cycle: got %b want 0", out_valid); else n_pass++;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL b_ready_after: got %b want 1", in_ready); else n_pass++;
  endtask

  task automatic test_fips_c1();
    int lat;
    out_ready = 1'b1;
    send_block(C_CT, C_K10, 1'b0, lat);
    n_checks++; if (lat !== 10) $display("FAIL c1_latency: got %0d want 10", lat); else n_pass++;
    n_checks++; if (from_blk(out_pt) !== C_PT) $display("FAIL c1_plaintext: got %h want %h", from_blk(out_pt), C_PT); else n_pass++;
    n_checks++; if (from_blk(dut.k) !== C_K0) $display("FAIL c1_round0_key: got %h want %h", from_blk(dut.k), C_K0); else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    int lat;
    out_ready = 1'b0;
    send_block(C_CT, C_K10, 1'b0, lat);
    n_checks++; if (lat !== 10) $display("FAIL bp_latency: got %0d want 10", lat); else n_pass++;
    in_valid = 1'b1; in_ct = to_blk(B_CT); in_key10 = to_blk(B_K10);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      n_checks++; if (out_valid !== 1'b1) $display("FAIL bp_hold_valid: cycle %0d got %b want 1", i, out_valid); else n_pass++;
      n_checks++; if (from_blk(out_pt) !== C_PT) $display("FAIL bp_hold_pt: cycle %0d got %h want %h", i, from_blk(out_pt), C_PT); else n_pass++;
      n_checks++; if (in_ready !== 1'b0) $display("FAIL bp_in_ready: cycle %0d got %b want 0", i, in_ready); else n_pass++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL bp_release_valid: got %b want 0", out_valid); else n_pass++;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL bp_release_ready: got %b want 1", in_ready); else n_pass++;
    @(posedge clk); #1;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL bp_no_latch: got %b want 1", in_ready); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int lat;
    int guard;
    out_ready = 1'b1;
    in_valid = 1'b1; in_ct = to_blk(B_CT); in_key10 = to_blk(B_K10);
    @(posedge clk); #1;
    in_ct = to_blk(C_CT); in_key10 = to_blk(C_K10);
    lat = 0;
    while (!out_valid && lat < 50) begin @(posedge clk); #1; lat++; end
    n_checks++; if (lat !== 10) $display("FAIL b2b_first_latency: got %0d want 10", lat); else n_pass++;
    n_checks++; if (from_blk(out_pt) !== B_PT) $display("FAIL b2b_first_pt: got %h want %h", from_blk(out_pt), B_PT); else n_pass++;
    @(posedge clk); #1;
    n_checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0)
      $display("FAIL b2b_dead_cycle: got ready=%b valid=%b want 1/0", in_ready, out_valid); else n_pass++;
    @(posedge clk); #1;
    n_checks++; if (in_ready !== 1'b0) $display("FAIL b2b_second_accept: in_ready %b want 0", in_ready); else n_pass++;
    in_valid = 1'b0;
    guard = 0;
    while (!out_valid && guard < 50) begin @(posedge clk); #1; guard++; end
    n_checks++; if (guard !== 10) $display("FAIL b2b_second_latency: got %0d want 10", guard); else n_pass++;
    n_checks++; if (from_blk(out_pt) !== C_PT) $display("FAIL b2b_second_pt: got %h want %h", from_blk(out_pt), C_PT); else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    int lat;
    int seen;
    out_ready = 1'b1;
    in_valid = 1'b1; in_ct = to_blk(C_CT); in_key10 = to_blk(C_K10);
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    n_checks++; if (dut.r !== 4'd5) $display("FAIL mid_round_index: got %0d want 5", dut.r); else n_pass++;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL mid_in_ready: got %b want 1", in_ready); else n_pass++;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL mid_out_valid: got %b want 0", out_valid); else n_pass++;
    n_checks++; if (from_blk(out_pt) !== 128'h0) $display("FAIL mid_out_pt: got %h want 0", from_blk(out_pt)); else n_pass++;
    seen = 0;
    repeat (12) begin @(posedge clk); #1; if (out_valid) seen++; end
    n_checks++; if (seen !== 0) $display("FAIL mid_aborted: out_valid seen %0d cycles want 0", seen); else n_pass++;
    send_block(C_CT, C_K10, 1'b0, lat);
    n_checks++; if (lat !== 10 || from_blk(out_pt) !== C_PT)
      $display("FAIL mid_recover: got lat=%0d pt=%h want 10 %h", lat, from_blk(out_pt), C_PT); else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_input_stability();
    int lat;
    out_ready = 1'b1;
    send_block(B_CT, B_K10, 1'b1, lat);
    n_checks++; if (lat !== 10 || from_blk(out_pt) !== B_PT)
      $display("FAIL stable_inputs: got lat=%0d pt=%h want 10 %h", lat, from_blk(out_pt), B_PT); else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    logic [127:0] key;
    logic [127:0] pt;
    logic [127:0] ct;
    logic [127:0] k10;
    int lat;
    int d;
    for (int t = 0; t < 8; t++) begin
      key = rnd128(); pt = rnd128();
      aes_enc(key, pt, ct, k10);
      out_ready = 1'b0;
      send_block(ct, k10, 1'b0, lat);
      n_checks++; if (lat !== 10) $display("FAIL rand_latency[%0d]: got %0d want 10", t, lat); else n_pass++;
      n_checks++; if (from_blk(out_pt) !== pt) $display("FAIL rand_pt[%0d]: got %h want %h", t, from_blk(out_pt), pt); else n_pass++;
      d = $urandom_range(0, 3);
      repeat (d) @(posedge clk);
      #1;
      n_checks++; if (out_valid !== 1'b1 || from_blk(out_pt) !== pt)
        $display("FAIL rand_hold[%0d]: got valid=%b pt=%h want 1 %h", t, out_valid, from_blk(out_pt), pt); else n_pass++;
      out_ready = 1'b1;
      @(posedge clk); #1;
      n_checks++; if (out_valid !== 1'b0) $display("FAIL rand_handshake[%0d]: got %b want 0", t, out_valid); else n_pass++;
    end
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_ct = '0; in_key10 = '0;
    build_sbox();
    test_reset();
    test_fips_b();
    test_fips_c1();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_input_stability();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
